subleq_mem_arbiter: RTL and testbench

//   Shares the single-port program/data memory between the subleq core (its

---
 rtl/subleq_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_subleq_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/subleq_mem_arbiter.sv
// Serialises subleq core and host loader accesses onto one synchronous single-port RAM.
// One transaction at a time: arbitrate, issue, wait out the read latency, acknowledge.
module subleq_mem_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int READ_LAT  = 1,
  parameter int HOST_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DATA_BITS-1:0] cpu_rdata,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_wdata,
  output logic                 host_ack,
  output logic [DATA_BITS-1:0] host_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic                 owner_host
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  state_t                 state, state_nxt;
  logic                   grant_host;
  logic                   lat_we;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [DATA_BITS-1:0]   lat_wdata;
  logic                   last_host;
  logic                   owner_q;
  logic [1:0]             cnt;
  logic [DATA_BITS-1:0]   cpu_rdata_q, host_rdata_q;

  // last_host resets to 1 so the core wins the first tie; owner_q is the visible owner and resets to 0
  assign grant_host = host_req & (~cpu_req | (HOST_PRIO != 0) | ~last_host);

  always_ff @(posedge clk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cpu_req || host_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? DONE : WAIT;
      WAIT:    if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      last_host    <= 1'b1;
      owner_q      <= 1'b0;
      cnt          <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (cpu_req || host_req) begin
            owner_q   <= grant_host;
            last_host <= grant_host;
            lat_we    <= grant_host ? host_we    : cpu_we;
            lat_addr  <= grant_host ? host_addr  : cpu_addr;
            lat_wdata <= grant_host ? host_wdata : cpu_wdata;
          end
        end
        WAIT: begin
          cnt <= cnt + 2'd1;
          // cnt reaches LAST_CNT exactly READ_LAT cycles after the ISSUE strobe
          if (cnt == LAST_CNT) begin
            if (owner_q) host_rdata_q <= mem_rdata;
            else         cpu_rdata_q  <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    host_ack  = 1'b0;
    busy      = (state != IDLE);
    if (state == ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
    end
    if (state == DONE) begin
      cpu_ack  = ~owner_q;
      host_ack = owner_q;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign owner_host = owner_q;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Directed bench for subleq_mem_arbiter: two instances (round-robin READ_LAT=1,
// host-priority READ_LAT=3) each backed by a behavioural RAM with matching latency.
module tb_subleq_mem_arbiter;

  logic       clk = 1'b0;
  logic       areset;
  logic       cpu_we, host_we;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;

  logic       a_cpu_req, a_host_req, b_cpu_req, b_host_req;
  logic       a_cpu_ack, a_host_ack, a_mem_en, a_mem_we, a_busy, a_owner_host;
  logic [7:0] a_cpu_rdata, a_host_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic       b_cpu_ack, b_host_ack, b_mem_en, b_mem_we, b_busy, b_owner_host;
  logic [7:0] b_cpu_rdata, b_host_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic [7:0] pa, pb1, pb2, pb3;

  int n_vec = 0;
  int n_bad = 0;
  logic e_acpu, e_ahost, e_bcpu, e_bhost;

  always #5 clk = ~clk;

  subleq_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .READ_LAT(1), .HOST_PRIO(0)) dut_a (
    .clk(clk), .areset(areset),
    .cpu_req(a_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .host_req(a_host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(a_host_ack), .host_rdata(a_host_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner_host(a_owner_host)
  );

  subleq_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .READ_LAT(3), .HOST_PRIO(1)) dut_b (
    .clk(clk), .areset(areset),
    .cpu_req(b_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .host_req(b_host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(b_host_ack), .host_rdata(b_host_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner_host(b_owner_host)
  );

  // RAM read data appears READ_LAT cycles after the address is presented
  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
    if (b_mem_en && b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
    pa  <= ram_a[a_mem_addr];
    pb1 <= ram_b[b_mem_addr];
    pb2 <= pb1;
    pb3 <= pb2;
  end
  assign a_mem_rdata = pa;
  assign b_mem_rdata = pb3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 8'hEE;
      ram_b[i] = 8'hEE;
    end
    ram_a[8'h10] = 8'h5A; ram_b[8'h10] = 8'h5A;
    ram_a[8'h30] = 8'h77; ram_b[8'h30] = 8'h77;

    areset = 1'b1;
    a_cpu_req = 1'b1; a_host_req = 1'b0; b_cpu_req = 1'b0; b_host_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
    host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;

    // reset held two cycles with cpu_req asserted
    tick();
    chk("rst1_mem_en", a_mem_en, 1'b0);
    tick();
    chk("rst_mem_en", a_mem_en, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_cpu_ack", a_cpu_ack, 1'b0);
    chk("rst_host_ack", a_host_ack, 1'b0);
    chk("rst_cpu_rdata", a_cpu_rdata, 8'h00);
    chk("rst_owner", a_owner_host, 1'b0);
    chk("rst_mem_addr", a_mem_addr, 8'h00);
    areset = 1'b0;

    // core read of 0x10 with READ_LAT=1
    tick();
    chk("rd_mem_en", a_mem_en, 1'b1);
    chk("rd_mem_addr", a_mem_addr, 8'h10);
    chk("rd_mem_we", a_mem_we, 1'b0);
    chk("rd_busy", a_busy, 1'b1);
    chk("rd_owner", a_owner_host, 1'b0);
    tick();
    chk("rd_t2_ack", a_cpu_ack, 1'b0);
    chk("rd_t2_mem_en", a_mem_en, 1'b0);
    tick();
    chk("rd_ack", a_cpu_ack, 1'b1);
    chk("rd_rdata", a_cpu_rdata, 8'h5A);
    chk("rd_host_ack", a_host_ack, 1'b0);
    a_cpu_req = 1'b0;
    tick();
    chk("rd_ack_drop", a_cpu_ack, 1'b0);
    chk("rd_idle", a_busy, 1'b0);

    // host write 0xC3 to 0x20, then core reads it back
    a_host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hC3;
    tick();
    chk("wr_mem_en", a_mem_en, 1'b1);
    chk("wr_mem_we", a_mem_we, 1'b1);
    chk("wr_mem_addr", a_mem_addr, 8'h20);
    chk("wr_mem_wdata", a_mem_wdata, 8'hC3);
    chk("wr_owner", a_owner_host, 1'b1);
    tick();
    chk("wr_host_ack", a_host_ack, 1'b1);
    chk("wr_cpu_ack", a_cpu_ack, 1'b0);
    a_host_req = 1'b0; host_we = 1'b0;
    tick();
    chk("wr_ack_drop", a_host_ack, 1'b0);
    chk("wr_idle_we", a_mem_we, 1'b0);
    chk("wr_idle_wdata", a_mem_wdata, 8'h00);
    a_cpu_req = 1'b1; cpu_addr = 8'h20;
    tick(); tick(); tick();
    chk("rb_ack", a_cpu_ack, 1'b1);
    chk("rb_rdata", a_cpu_rdata, 8'hC3);
    chk("rb_host_rdata", a_host_rdata, 8'h00);
    a_cpu_req = 1'b0;
    tick();

    // contention: round-robin on dut_a, host priority on dut_b
    areset = 1'b1;
    tick();
    areset = 1'b0;
    cpu_addr = 8'h10; host_addr = 8'h30;
    a_cpu_req = 1'b1; a_host_req = 1'b1; b_cpu_req = 1'b1; b_host_req = 1'b1;
    for (int t = 1; t <= 23; t++) begin
      tick();
      e_acpu  = (t == 3) || (t == 11) || (t == 19) || (t == 23);
      e_ahost = (t == 7) || (t == 15);
      e_bhost = (t == 5) || (t == 11) || (t == 17);
      e_bcpu  = (t == 23);
      chk("rr_cpu_ack", a_cpu_ack, e_acpu);
      chk("rr_host_ack", a_host_ack, e_ahost);
      chk("hp_cpu_ack", b_cpu_ack, e_bcpu);
      chk("hp_host_ack", b_host_ack, e_bhost);
      if (e_acpu)  chk("rr_cpu_rdata", a_cpu_rdata, 8'h5A);
      if (e_ahost) chk("rr_host_rdata", a_host_rdata, 8'h77);
      if (e_bhost) chk("hp_host_rdata", b_host_rdata, 8'h77);
      if (e_bcpu)  chk("hp_cpu_rdata", b_cpu_rdata, 8'h5A);
      if (t == 17) begin
        a_host_req = 1'b0;
        b_host_req = 1'b0;
      end
      if (t == 23) begin
        a_cpu_req = 1'b0;
        b_cpu_req = 1'b0;
      end
    end
    tick();
    chk("rr_end_busy", a_busy, 1'b0);
    chk("hp_end_busy", b_busy, 1'b0);

    // reset during WAIT with READ_LAT=3 aborts silently
    areset = 1'b1;
    tick();
    areset = 1'b0;
    b_cpu_req = 1'b1;
    tick();
    tick();
    tick();
    chk("ab_busy_wait", b_busy, 1'b1);
    chk("ab_no_ack_wait", b_cpu_ack, 1'b0);
    areset = 1'b1;
    tick();
    chk("ab_busy", b_busy, 1'b0);
    chk("ab_cpu_ack", b_cpu_ack, 1'b0);
    chk("ab_mem_en", b_mem_en, 1'b0);
    chk("ab_rdata_clr", b_cpu_rdata, 8'h00);
    areset = 1'b0;
    for (int u = 1; u <= 5; u++) begin
      tick();
      chk("ab_retry_ack", b_cpu_ack, (u == 5));
      if (u == 5) begin
        chk("ab_retry_rdata", b_cpu_rdata, 8'h5A);
        b_cpu_req = 1'b0;
      end
    end
    tick();
    chk("ab_end_busy", b_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
